if_queue: RTL and testbench
===========================

IF_QUEUE -- requirements
Module: if_queue

Interface
REQ-001 Parameter DEPTH, default 4, means queue entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, means the first fetch address after reset.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-low; rst=0 at a rising clk edge resets the block.
REQ-005 Port imem_addr, output, 32 bits: fetch address to instruction memory; equals fetch_pc.
REQ-006 Port imem_rdata, input, 32 bits: instruction at imem_addr, valid combinationally in the same cycle.
REQ-007 Port redirect_valid, input, 1 bit: branch/jump taken in EX; flushes the queue.
REQ-008 Port redirect_pc, input, 32 bits: target address, sampled when redirect_valid=1.
REQ-009 Port out_valid, output, 1 bit: queue head holds an instruction.
REQ-010 Port out_instr, output, 32 bits: head instruction; 32'h0 (NOP) when out_valid=0.
REQ-011 Port out_pc, output, 32 bits: address of the head instruction; 32'h0 when out_valid=0.
REQ-012 Port out_ready, input, 1 bit: decode accepts the head this cycle.
REQ-013 Port level, output, clog2(DEPTH)+1 bits: current occupancy, 0..DEPTH.

Function
REQ-014 Pop SHALL occur when out_valid=1, out_ready=1 and redirect_valid=0.
REQ-015 Push SHALL occur when redirect_valid=0 and (level<DEPTH or pop): it writes {imem_rdata, fetch_pc} at the tail and sets fetch_pc <= fetch_pc+4.
REQ-016 A pushed entry SHALL reach the head no earlier than the next cycle; latency from fetch to out_valid on an empty queue is 1 cycle.
REQ-017 A simultaneous push and pop SHALL leave level unchanged; this is legal at level=DEPTH and at level=1.
REQ-018 When level=DEPTH and there is no pop: no push; fetch_pc and imem_addr hold.
REQ-019 When level=0: out_valid=0; out_ready is ignored.
REQ-020 redirect_valid=1 SHALL, in the same cycle, empty the queue (level <= 0), set fetch_pc <= redirect_pc, and suppress both push and pop; out_valid=0 the next cycle.
REQ-021 The cycle after a redirect SHALL fetch from redirect_pc; its entry appears at the head one cycle later.
REQ-022 Head/tail pointers SHALL wrap modulo DEPTH; fetch_pc SHALL wrap modulo 2^32 with no error.
REQ-023 out_instr and out_pc SHALL come from registered storage, with no combinational path from imem_rdata.
REQ-024 Entries SHALL leave in push order, with no loss and no duplication.

Reset
REQ-025 On rst=0: fetch_pc=RESET_PC, level=0, head=tail=0, out_valid=0, out_instr=0, out_pc=0.
REQ-026 Reset SHALL take priority over redirect, push and pop.
REQ-027 A reset mid-operation SHALL discard all entries; the first fetch after rst returns to 1 is from RESET_PC.
REQ-028 Storage contents need not be cleared; the outputs are masked by out_valid.

Structure
REQ-029 The shared package SHALL hold: DEPTH default, RESET_PC default, the NOP_INSTR=32'h0 constant, and an entry typedef {instr[31:0], pc[31:0]}.
REQ-030 Circular-buffer storage and pointers SHALL live in sub-module if_fifo (push, pop, flush, level); if_queue owns fetch_pc and the push/pop/redirect decisions.

Verification
REQ-031 Reset, then rst=1 with out_ready=1 and imem returning addr+1000 → imem_addr sequence 0,4,8; out_pc 0,4,8 from cycle 2; out_instr 1000,1004,1008.
REQ-032 out_ready=0 for 6 cycles → level counts 1,2,3,4,4,4; imem_addr holds at 16 once full; releasing out_ready delivers pcs 0,4,8,12,16 in order.
REQ-033 Full queue with out_ready=1 → push and pop every cycle; level stays 4; no pc skipped.
REQ-034 redirect_valid=1 with redirect_pc=32'h40 while level=3 → next cycle level=0, out_valid=0, imem_addr=32'h40; the cycle after, out_pc=32'h40.
REQ-035 rst=0 asserted mid-stream at level=2 → next cycle out_valid=0, out_instr=0, imem_addr=RESET_PC.
REQ-036 Redirect to 32'hFFFF_FFFC → the following fetches are FFFF_FFFC then 0000_0000.

Source files
------------

// File: rtl/if_queue_pkg.sv
// -----------------------------------------------------------------------------
// if_queue_pkg
// Shared definitions for the instruction-fetch queue: default parameters,
// the NOP encoding shown on the output when the queue is empty, and the
// queue entry layout.
// -----------------------------------------------------------------------------
package if_queue_pkg;

    localparam int          DEPTH_DEFAULT    = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

endpackage : if_queue_pkg

// File: rtl/if_fifo.sv
// -----------------------------------------------------------------------------
// if_fifo
// Circular buffer of fetch entries with head/tail pointers and occupancy.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset (clears pointers and level)
//   push_i       write push_data_i at the tail
//   push_data_i  entry to write
//   pop_i        advance the head
//   flush_i      empty the buffer; overrides push and pop
//   head_o       entry at the head (raw storage; caller masks when empty)
//   level_o      occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module if_fifo
    import if_queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  entry_t                 push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output entry_t                 head_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int               PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   LEVEL_ONE = (PTR_W + 1)'(1);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [PTR_W:0]     level_q, level_d;

    // NOTE: every next-state signal is given its hold value first, so no path
    // through this block leaves one unassigned and no latch is inferred.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            level_d = '0;
        end else begin
            // Pointers are PTR_W bits wide, so DEPTH being a power of two makes
            // the natural overflow the modulo-DEPTH wrap.
            if (push_i) tail_d = tail_q + PTR_ONE;
            if (pop_i)  head_d = head_q + PTR_ONE;
            case ({push_i, pop_i})
                2'b10:   level_d = level_q + LEVEL_ONE;
                2'b01:   level_d = level_q - LEVEL_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
        end
    end

    // NOTE: storage is deliberately not reset; stale contents are never
    // visible because the head is masked whenever level is zero.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[tail_q] <= push_data_i;
    end

    // A push and pop at full hit the same slot: the read sees the old entry
    // and the write lands at the edge, which is exactly the desired order.
    assign head_o  = mem_q[head_q];
    assign level_o = level_q;

endmodule : if_fifo

// File: rtl/if_queue.sv
// -----------------------------------------------------------------------------
// if_queue
// Instruction-fetch front end: owns the fetch PC, fetches one instruction per
// cycle into a small queue, and presents the oldest entry to decode.
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-low reset
//   imem_addr       fetch address (the fetch PC)
//   imem_rdata      instruction at imem_addr, same cycle
//   redirect_valid  taken branch/jump: flush queue and refetch
//   redirect_pc     target address used when redirect_valid=1
//   out_valid       head entry present
//   out_instr       head instruction, NOP when empty
//   out_pc          head address, 0 when empty
//   out_ready       decode consumes the head this cycle
//   level           queue occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module if_queue
    import if_queue_pkg::*;
#(
    parameter int          DEPTH    = DEPTH_DEFAULT,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [31:0]            imem_addr,
    input  logic [31:0]            imem_rdata,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic                   out_valid,
    output logic [31:0]            out_instr,
    output logic [31:0]            out_pc,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level
);

    localparam int               LVL_W      = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        push, pop, full;
    entry_t      push_entry, head_entry;

    assign full      = (level == FULL_LEVEL);
    assign out_valid = (level != '0);

    // Redirect suppresses both sides; at full a push is still allowed when the
    // head leaves in the same cycle.
    assign pop  = out_valid && out_ready && !redirect_valid;
    assign push = !redirect_valid && (!full || pop);

    assign push_entry = '{instr: imem_rdata, pc: fetch_pc_q};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid)  fetch_pc_d = redirect_pc;
        else if (push)       fetch_pc_d = fetch_pc_q + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (!rst) fetch_pc_q <= RESET_PC;
        else      fetch_pc_q <= fetch_pc_d;
    end

    if_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .head_o      (head_entry),
        .level_o     (level)
    );

    assign imem_addr = fetch_pc_q;
    assign out_instr = out_valid ? head_entry.instr : NOP_INSTR;
    assign out_pc    = out_valid ? head_entry.pc    : 32'h0;

endmodule : if_queue

// File: tb/tb_if_queue.sv
// -----------------------------------------------------------------------------
// tb_if_queue
// Directed scenarios followed by randomized traffic. Instruction memory
// returns addr+1000. A reference model holds the queue as a list of PCs and
// the next fetch address, updated from the behavioural rules of the block.
// -----------------------------------------------------------------------------
module tb_if_queue;
    import if_queue_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr, out_pc;
    logic        out_ready;
    logic [2:0]  level;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: PCs in queue order, plus next fetch address.
    logic [31:0] m_q [$];
    logic [31:0] m_pc;

    if_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .level          (level)
    );

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr + 32'd1000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [31:0] e_pc, e_instr;
        e_pc    = (m_q.size() > 0) ? m_q[0] : 32'h0;
        e_instr = (m_q.size() > 0) ? m_q[0] + 32'd1000 : NOP_INSTR;
        chk("model_imem_addr", imem_addr, m_pc);
        chk("model_level", {29'b0, level}, 32'(m_q.size()));
        chk("model_out_valid", {31'b0, out_valid}, {31'b0, m_q.size() > 0});
        chk("model_out_pc", out_pc, e_pc);
        chk("model_out_instr", out_instr, e_instr);
    endtask

    // Drive one cycle's inputs, advance the model, clock, then compare.
    task automatic cycle(input logic r, input logic ready, input logic rv,
                         input logic [31:0] rpc);
        rst            = r;
        out_ready      = ready;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (!r) begin
            m_q.delete();
            m_pc = RST_PC;
        end else if (rv) begin
            m_q.delete();
            m_pc = rpc;
        end else begin
            if (m_q.size() > 0 && ready) void'(m_q.pop_front());
            if (m_q.size() < DEPTH) begin
                m_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    initial begin
        int exp_lvl [6];
        logic [31:0] exp_pc [5];
        exp_lvl = '{1, 2, 3, 4, 4, 4};
        exp_pc  = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16};

        m_pc = RST_PC;
        rst = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

        // Reset state
        cycle(1'b0, 1'b1, 1'b1, 32'h100);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_imem_addr", imem_addr, RST_PC);
        chk("rst_level", {29'b0, level}, 32'd0);

        // Streaming with decode always ready
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("stream_addr1", imem_addr, 32'd4);
        chk("stream_pc0", out_pc, 32'd0);
        chk("stream_instr0", out_instr, 32'd1000);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("stream_addr2", imem_addr, 32'd8);
        chk("stream_pc1", out_pc, 32'd4);
        chk("stream_instr1", out_instr, 32'd1004);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("stream_pc2", out_pc, 32'd8);
        chk("stream_instr2", out_instr, 32'd1008);

        // Back-pressure: fill to DEPTH, fetch stalls
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
            chk("fill_level", {29'b0, level}, 32'(exp_lvl[i]));
            if (i >= 3) chk("fill_addr_hold", imem_addr, 32'd16);
        end

        // Release at full: push and pop each cycle, no pc skipped
        for (int i = 0; i < 5; i++) begin
            chk("drain_order", out_pc, exp_pc[i]);
            cycle(1'b1, 1'b1, 1'b0, 32'h0);
            chk("full_level_hold", {29'b0, level}, 32'd4);
        end

        // Redirect at level 3
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk("pre_redir_level", {29'b0, level}, 32'd3);
        cycle(1'b1, 1'b1, 1'b1, 32'h40);
        chk("redir_level", {29'b0, level}, 32'd0);
        chk("redir_out_valid", {31'b0, out_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'h40);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk("redir_head_pc", out_pc, 32'h40);

        // Reset mid-stream at level 2
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk("pre_rst_level", {29'b0, level}, 32'd2);
        cycle(1'b0, 1'b1, 1'b1, 32'h80);
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_out_instr", out_instr, 32'd0);
        chk("midrst_addr", imem_addr, RST_PC);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk("midrst_first_pc", out_pc, RST_PC);

        // PC wrap at 2^32
        cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_addr1", imem_addr, 32'h0000_0000);
        chk("wrap_head0", out_pc, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_head1", out_pc, 32'h0000_0000);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic        r, rdy, rv;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 49) != 0);
            rdy = ($urandom_range(0, 9) < 6);
            rv  = ($urandom_range(0, 11) == 0);
            rpc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            cycle(r, rdy, rv, rpc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_if_queue
